// File: rtl/ppc_mem_pkg.sv
// Shared types and sizing for the PPC core memory-port arbiters.
package ppc_mem_pkg;
    localparam int ADDR_W     = 61;
    localparam int DATA_W     = 64;
    localparam int STARVE_DEF = 3;
    localparam int MAXOUT_DEF = 4;

    typedef enum logic {
        TAG_FETCH = 1'b0,
        TAG_LOAD  = 1'b1
    } tag_e;
endpackage

// File: rtl/tag_fifo.sv
// In-order owner-tag FIFO: records who issued each outstanding read so the
// response can be routed back. Push while full and pop while empty are ignored.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       push,
    input  logic                       push_tag,
    input  logic                       pop,
    output logic                       pop_tag,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_tag = tags[rd_ptr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one pipelined memory read port between fetch and load. Load has
// priority; a starvation counter forces fetch through after STARVE denials.
module mem_read_arbiter
    import ppc_mem_pkg::*;
#(
    parameter int MAXOUT = MAXOUT_DEF,
    parameter int STARVE = STARVE_DEF
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              fetchValid,
    input  logic [0:ADDR_W-1] fetchAddr,
    output logic              fetchReady,
    output logic              fetchRespValid,
    output logic [0:DATA_W-1] fetchRespData,
    input  logic              loadValid,
    input  logic [0:ADDR_W-1] loadAddr,
    output logic              loadReady,
    output logic              loadRespValid,
    output logic [0:DATA_W-1] loadRespData,
    output logic              memValid,
    output logic [0:ADDR_W-1] memAddr,
    input  logic              memReady,
    input  logic              memRespValid,
    input  logic [0:DATA_W-1] memRespData,
    output logic              protoErr
);
    localparam int SW = $clog2(STARVE + 1);
    localparam int CW = $clog2(MAXOUT + 1);

    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] count;
    logic          full, empty, head_bit;
    tag_e          head_tag;
    logic          can_issue, force_fetch, grant_load, grant_fetch, resp_pop;

    // Gating with rstN keeps the handshake outputs low during reset.
    assign can_issue   = rstN & memReady & ~full;
    assign force_fetch = fetchValid & (starve_cnt == SW'(STARVE));
    assign grant_load  = can_issue & loadValid & ~force_fetch;
    assign grant_fetch = can_issue & fetchValid & ~grant_load;

    assign fetchReady = grant_fetch;
    assign loadReady  = grant_load;
    assign memValid   = grant_fetch | grant_load;
    assign memAddr    = grant_load  ? loadAddr  :
                        grant_fetch ? fetchAddr : '0;

    assign head_tag = tag_e'(head_bit);
    assign resp_pop = memRespValid & ~empty;

    tag_fifo #(.DEPTH(MAXOUT)) u_tags (
        .clk      (clk),
        .rstN     (rstN),
        .push     (memValid),
        .push_tag (grant_load),
        .pop      (resp_pop),
        .pop_tag  (head_bit),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            starve_cnt <= '0;
        else if (grant_fetch || !fetchValid)
            starve_cnt <= '0;
        else if (grant_load && starve_cnt != SW'(STARVE))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Response data registers only load for their own owner, so they hold otherwise.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetchRespValid <= 1'b0;
            loadRespValid  <= 1'b0;
            fetchRespData  <= '0;
            loadRespData   <= '0;
            protoErr       <= 1'b0;
        end else begin
            fetchRespValid <= resp_pop && head_tag == TAG_FETCH;
            loadRespValid  <= resp_pop && head_tag == TAG_LOAD;
            if (resp_pop && head_tag == TAG_FETCH)
                fetchRespData <= memRespData;
            if (resp_pop && head_tag == TAG_LOAD)
                loadRespData <= memRespData;
            if (memRespValid && empty)
                protoErr <= 1'b1;
        end
    end

    a_full_count : assert property (@(posedge clk) disable iff (!rstN)
        full == (count == CW'(MAXOUT)));
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a queue-based reference model
// checked every cycle, plus literal checks on the key scenarios.
module tb_mem_read_arbiter;
    localparam int MAXOUT = 4;
    localparam int STARVE = 3;

    logic        clk, rstN;
    logic        fetchValid, loadValid, memReady, memRespValid;
    logic [0:60] fetchAddr, loadAddr, memAddr;
    logic [0:63] memRespData, fetchRespData, loadRespData;
    logic        fetchReady, loadReady, memValid;
    logic        fetchRespValid, loadRespValid, protoErr;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    mem_read_arbiter #(.MAXOUT(MAXOUT), .STARVE(STARVE)) dut (
        .clk(clk), .rstN(rstN),
        .fetchValid(fetchValid), .fetchAddr(fetchAddr), .fetchReady(fetchReady),
        .fetchRespValid(fetchRespValid), .fetchRespData(fetchRespData),
        .loadValid(loadValid), .loadAddr(loadAddr), .loadReady(loadReady),
        .loadRespValid(loadRespValid), .loadRespData(loadRespData),
        .memValid(memValid), .memAddr(memAddr), .memReady(memReady),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .protoErr(protoErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding owners as a queue (0 fetch, 1 load).
    bit          q[$];
    int          starve = 0;
    bit          m_fv = 0, m_lv = 0, m_perr = 0;
    logic [63:0] m_fd = '0, m_ld = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit can, force_f, gl, gf, owner;
            logic [63:0] addr;
            if (!rstN) begin
                q.delete();
                starve = 0; m_fv = 0; m_lv = 0; m_perr = 0; m_fd = '0; m_ld = '0;
                gl = 0; gf = 0;
            end else begin
                can     = memReady && (q.size() < MAXOUT);
                force_f = fetchValid && (starve == STARVE);
                gl      = can && loadValid && !force_f;
                gf      = can && fetchValid && !gl;
            end
            addr = gl ? 64'(loadAddr) : gf ? 64'(fetchAddr) : 64'd0;
            chk("fetch_ready", fetchReady, gf);
            chk("load_ready", loadReady, gl);
            chk("mem_valid", memValid, gl || gf);
            chk("mem_addr", memAddr, addr);
            chk("fetch_resp_valid", fetchRespValid, m_fv);
            chk("load_resp_valid", loadRespValid, m_lv);
            chk("fetch_resp_data", fetchRespData, m_fd);
            chk("load_resp_data", loadRespData, m_ld);
            chk("proto_err", protoErr, m_perr);
            if (rstN) begin
                m_fv = 0; m_lv = 0;
                if (memRespValid) begin
                    if (q.size() == 0) m_perr = 1;
                    else begin
                        owner = q.pop_front();
                        if (owner) begin m_lv = 1; m_ld = memRespData; end
                        else       begin m_fv = 1; m_fd = memRespData; end
                    end
                end
                if (gl) q.push_back(1'b1);
                if (gf) q.push_back(1'b0);
                if (gf || !fetchValid) starve = 0;
                else if (gl && starve < STARVE) starve++;
            end
        end
    end

    task automatic drive(input bit fv, input logic [63:0] fa, input bit lv,
                         input logic [63:0] la, input bit mr, input bit rv,
                         input logic [63:0] rd);
        fetchValid   = fv;
        fetchAddr    = fa[60:0];
        loadValid    = lv;
        loadAddr     = la[60:0];
        memReady     = mr;
        memRespValid = rv;
        memRespData  = rd;
    endtask

    task automatic half();
        @(negedge clk); #1;
    endtask

    task automatic fin();
        @(posedge clk); #1;
    endtask

    task automatic step(input bit fv, input logic [63:0] fa, input bit lv,
                        input logic [63:0] la, input bit mr, input bit rv,
                        input logic [63:0] rd);
        drive(fv, fa, lv, la, mr, rv, rd);
        half();
        fin();
    endtask

    logic [63:0] dvec [4] = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
    bit          dfetch [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rstN = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        step(0, 0, 0, 0, 1, 0, 0);

        // single fetch, response three cycles later
        drive(1, 64'h10, 0, 0, 1, 0, 0);
        half();
        chk("t1_fetch_ready", fetchReady, 1);
        chk("t1_mem_addr", memAddr, 64'h10);
        fin();
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 64'hDEADBEEF00000001);
        chk("t1_resp_valid", fetchRespValid, 1);
        chk("t1_resp_data", fetchRespData, 64'hDEADBEEF00000001);
        chk("t1_load_quiet", loadRespValid, 0);

        // both requesting: L,L,L,F repeating
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'h100, 1, 64'h200, 1, i > 0, 64'h1000 + 64'(i));
            half();
            chk("t2_fetch_slot", fetchReady, (i % 4) == 3);
            chk("t2_load_slot", loadReady, (i % 4) != 3);
            fin();
        end
        step(0, 0, 0, 0, 1, 1, 64'h1008);

        // fill to MAXOUT, then full+pop blocks issue, the freed slot is used next cycle
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 64'h300 + 64'(i), 1, 0, 0);
            half();
            chk("t3_fill", loadReady, i < 4);
            fin();
        end
        drive(0, 0, 1, 64'h400, 1, 1, 64'hA0);
        half();
        chk("t3_full_pop_noissue", memValid, 0);
        fin();
        drive(0, 0, 1, 64'h404, 1, 0, 0);
        half();
        chk("t3_slot_reused", loadReady, 1);
        fin();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 1, 64'hB0 + 64'(i));
            chk("t3_drain", loadRespValid, 1);
        end

        // interleaved F,L,L,F routed back in order
        step(1, 64'h500, 0, 0, 1, 0, 0);
        step(0, 0, 1, 64'h510, 1, 0, 0);
        step(0, 0, 1, 64'h520, 1, 0, 0);
        step(1, 64'h530, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 1, 1, dvec[k]);
            chk("t4_fetch_owner", fetchRespValid, dfetch[k]);
            chk("t4_load_owner", loadRespValid, !dfetch[k]);
            chk("t4_data", dfetch[k] ? fetchRespData : loadRespData, dvec[k]);
        end

        // unexpected response
        step(0, 0, 0, 0, 1, 1, 64'hBAD);
        chk("t5_proto_err", protoErr, 1);
        chk("t5_no_fetch_resp", fetchRespValid, 0);
        chk("t5_no_load_resp", loadRespValid, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t5_sticky", protoErr, 1);

        // reset with reads outstanding
        for (int i = 0; i < 3; i++) step(0, 0, 1, 64'h600 + 64'(i), 1, 0, 0);
        step(0, 0, 1, 64'h610, 1, 1, 64'hE0);
        chk("t6_pre_reset_resp", loadRespValid, 1);
        rstN = 1'b0;
        #1;
        chk("t6_rst_resp_valid", loadRespValid, 0);
        chk("t6_rst_resp_data", loadRespData, 0);
        chk("t6_rst_proto_err", protoErr, 0);
        chk("t6_rst_ready", loadReady, 0);
        chk("t6_rst_mem_valid", memValid, 0);
        step(0, 0, 1, 64'h620, 1, 1, 64'hE1);
        rstN = 1'b1;
        drive(1, 64'h40, 0, 0, 1, 0, 0);
        half();
        chk("t6_post_issue", fetchReady, 1);
        fin();
        step(0, 0, 0, 0, 1, 1, 64'hCAFE);
        chk("t6_post_resp", fetchRespValid, 1);
        chk("t6_post_data", fetchRespData, 64'hCAFE);
        step(0, 0, 0, 0, 1, 1, 64'hDEAD);
        chk("t6_stale_resp_err", protoErr, 1);
        chk("t6_stale_no_resp", loadRespValid, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares one pipelined memory read port between the instruction-fetch requester and the load requester of the PPC core. Requests use valid/ready handshakes. Responses return in order and are routed back to their owner through an in-order tag FIFO. Load requests win by default. A starvation counter guarantees forward progress for fetch.

## Interface
- MAXOUT, 4: maximum outstanding memory reads (tag FIFO depth), ≥1
- STARVE, 3: consecutive fetch denials after which fetch is forced to win, ≥1
- clk  in  1  clock; all state updates on posedge
- rstN  in  1  asynchronous active-low reset
- fetchValid  in  1  fetch request pending; addr held stable until accepted
- fetchAddr  in  [0:60]  doubleword address
- fetchReady  out  1  fetch request accepted this cycle
- fetchRespValid  out  1  one-cycle pulse, fetch data valid
- fetchRespData  out  [0:63]  returned doubleword
- loadValid / loadAddr / loadReady  in / in [0:60] / out  load request; same rules as fetch
- loadRespValid / loadRespData  out 1 / out [0:63]  load response
- memValid  out  1  read issued to memory
- memAddr  out  [0:60]  issued address; 0 when memValid=0
- memReady  in  1  memory accepts a read this cycle
- memRespValid  in  1  memory returns data (in issue order)
- memRespData  in  [0:63]  returned data
- protoErr  out  1  sticky; set on response with no outstanding read

## Operation
- Transfer on a requester when valid & ready; memory issue on memValid & memReady.
- canIssue = memReady & (count < MAXOUT). No bypass when full: a pop in the same cycle does not free a slot until the next cycle.
- forceFetch = fetchValid & (starveCnt == STARVE).
- Grant rules:
  - Load wins if loadValid & ~forceFetch.
  - Otherwise fetch wins if fetchValid.
  - No grant if ~canIssue.
  - At most one grant per cycle.
- fetchReady/loadReady = canIssue & granted. memValid = any grant. memAddr = granted address.
- starveCnt (width clog2(STARVE+1)):
  - +1 when fetchValid & load granted.
  - Reset to 0 on fetch grant or when fetchValid=0.
  - Holds otherwise; saturates at STARVE.
- Tag FIFO:
  - Push the owner tag (TAG_FETCH/TAG_LOAD) on issue.
  - Pop on memRespValid.
  - Simultaneous push+pop leaves count unchanged. Pointers wrap modulo MAXOUT.
- Response routing:
  - Registered. memRespValid in cycle M gives the owner's RespValid=1 in cycle M+1, with RespData = memRespData captured at M.
  - The other owner's RespValid is 0.
  - RespData holds its last value when not valid.
- memRespValid with count==0: data dropped, no RespValid, protoErr set until reset.
- Reset (any time, including mid-operation): FIFO emptied, count 0, starveCnt 0. Responses arriving afterwards for pre-reset reads count as unexpected.

## Timing
- Reset values:
  - fetchRespValid, loadRespValid, protoErr = 0.
  - fetchRespData, loadRespData = 0.
  - memValid, fetchReady, loadReady = 0 while rstN low.
- Issue is combinational: a request accepted in cycle N appears on memValid/memAddr in cycle N.
- Response latency: memory response cycle M → requester response cycle M+1.
- Throughput: one issue and one response per cycle sustained when memory allows.
- fetchReady/loadReady depend combinationally on both valids, memReady and count. Requesters must not make valid depend on ready.

## Structure
- Package ppc_mem_pkg holds:
  - ADDR_W=61, DATA_W=64
  - tag type {TAG_FETCH, TAG_LOAD}
  - STARVE and MAXOUT defaults
- Sub-module tag_fifo: parameterised depth, 1-bit tag, push/pop/full/empty/count, async active-low reset. Reused by later store/write-port arbiters.
- Grant logic, starvation counter and response registers stay in mem_read_arbiter.

## Test plan
- Single fetch, addr 0x10, memReady=1, response at +3 with data 0xDEADBEEF00000001 → fetchReady cycle 0, fetchRespValid at cycle 4 with that data, loadRespValid 0.
- fetchValid and loadValid held continuously, STARVE=3, memory always ready → load granted 3 cycles, fetch granted on 4th, pattern L,L,L,F repeating.
- MAXOUT=4, memory never responds → four issues accepted, then memValid=0 and both readies 0. One memRespValid → next cycle one issue allowed. Full + pop same cycle → no issue that cycle.
- Interleaved issues F,L,L,F with responses D0..D3 back-to-back → fetch gets D0,D3; load gets D1,D2, each one cycle after arrival.
- memRespValid with nothing outstanding → no RespValid, protoErr=1 and stays 1 until rstN low.
- Assert rstN low with 3 reads outstanding → all outputs 0 immediately. After release, the first issue pushes into an empty FIFO (count 1) and its response routes correctly.
